// File: rtl/lbdr_route_unit.sv
// lbdr_route_unit: logic-based distributed routing for one 2D-mesh input port.
// A header at the input buffer head is evaluated against the configured
// routing bits (Rxy), connectivity bits (Cx) and own address. The resulting
// output-port vector is then locked until the packet's tail flit has been
// forwarded. Packets that have no legal output port are drained and counted.
module lbdr_route_unit #(
  parameter int unsigned X_W     = 2,
  parameter int unsigned Y_W     = 2,
  parameter int unsigned CNT_W   = 8,
  parameter logic [7:0]  RXY_RST = 8'd60,
  parameter logic [3:0]  CX_RST  = 4'hF,
  parameter int unsigned CUR_RST = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_rxy,
  input  logic [3:0]           cfg_cx,
  input  logic [X_W+Y_W-1:0]   cfg_cur,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           flit_id,
  input  logic [X_W+Y_W-1:0]   dst_addr,
  input  logic                 out_ready,
  output logic                 route_valid,
  output logic [4:0]           port_vec,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 err_proto
);

  localparam int unsigned A_W = X_W + Y_W;

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOCK = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // port_vec bit positions {L,S,W,E,N}
  localparam int unsigned P_N = 0;
  localparam int unsigned P_E = 1;
  localparam int unsigned P_W = 2;
  localparam int unsigned P_S = 3;
  localparam int unsigned P_L = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // state and registered outputs
  logic [1:0]       state_q,       state_d;
  logic [4:0]       port_vec_q,    port_vec_d;
  logic             route_valid_q, route_valid_d;
  logic [CNT_W-1:0] drop_cnt_q,    drop_cnt_d;
  logic             err_proto_q,   err_proto_d;
  logic             first_q,       first_d;

  // configuration registers
  logic [7:0]       rxy_q, rxy_d;
  logic [3:0]       cx_q,  cx_d;
  logic [A_W-1:0]   cur_q, cur_d;

  // routing decode
  logic [X_W-1:0]   x_dst, x_cur;
  logic [Y_W-1:0]   y_dst, y_cur;
  logic             n1, s1, e1, w1;
  logic             rne, rnw, ren, res, rwn, rws, rse, rsw;
  logic             cn, ce, cw, cs;
  logic [4:0]       cand_c;

  logic             in_ready_c;
  logic             fire_c;
  logic             is_hdr, is_tail;

  // PAYLOAD bit carries no extra meaning beyond "not header"
  logic             unused_payload_bit;
  assign unused_payload_bit = flit_id[1];

  assign is_hdr  = flit_id[0];
  assign is_tail = flit_id[2];

  // Split addresses into mesh coordinates, y in the upper bits
  always_comb begin
    x_dst = dst_addr[X_W-1:0];
    y_dst = dst_addr[A_W-1:X_W];
    x_cur = cur_q[X_W-1:0];
    y_cur = cur_q[A_W-1:X_W];
  end

  // Name the individual configuration bits
  always_comb begin
    rne = rxy_q[0];
    rnw = rxy_q[1];
    ren = rxy_q[2];
    res = rxy_q[3];
    rwn = rxy_q[4];
    rws = rxy_q[5];
    rse = rxy_q[6];
    rsw = rxy_q[7];
    cn  = cx_q[0];
    ce  = cx_q[1];
    cw  = cx_q[2];
    cs  = cx_q[3];
  end

  // Relative-position comparators against the configured own address
  always_comb begin
    n1 = (y_dst < y_cur);
    s1 = (y_dst > y_cur);
    e1 = (x_dst > x_cur);
    w1 = (x_dst < x_cur);
  end

  // LBDR candidate output ports; diagonal turns gated by Rxy, all by Cx
  always_comb begin
    cand_c      = '0;
    cand_c[P_N] = ((n1 & ~e1 & ~w1) | (n1 & e1 & rne) | (n1 & w1 & rnw)) & cn;
    cand_c[P_E] = ((e1 & ~n1 & ~s1) | (e1 & n1 & ren) | (e1 & s1 & res)) & ce;
    cand_c[P_W] = ((w1 & ~n1 & ~s1) | (w1 & n1 & rwn) | (w1 & s1 & rws)) & cw;
    cand_c[P_S] = ((s1 & ~e1 & ~w1) | (s1 & e1 & rse) | (s1 & w1 & rsw)) & cs;
    cand_c[P_L] = ~n1 & ~s1 & ~e1 & ~w1;
  end

  assign fire_c = in_valid & in_ready_c;

  // Next-state, consume handshake and registered-output updates
  always_comb begin
    state_d       = state_q;
    port_vec_d    = port_vec_q;
    route_valid_d = route_valid_q;
    drop_cnt_d    = drop_cnt_q;
    err_proto_d   = err_proto_q;
    first_d       = first_q;
    rxy_d         = rxy_q;
    cx_d          = cx_q;
    cur_d         = cur_q;
    in_ready_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Config has priority; a header waiting in the same cycle is
        // evaluated next cycle against the new configuration.
        if (cfg_we) begin
          rxy_d = cfg_rxy;
          cx_d  = cfg_cx;
          cur_d = cfg_cur;
        end
        if (in_valid && !is_hdr) begin
          // Non-header with no open packet: discard and flag
          in_ready_c  = 1'b1;
          err_proto_d = 1'b1;
        end else if (in_valid && !cfg_we) begin
          // Header stays at the buffer head; it is forwarded from LOCK/DROP
          if (cand_c != 5'b0) begin
            state_d       = ST_LOCK;
            port_vec_d    = cand_c;
            route_valid_d = 1'b1;
            first_d       = 1'b1;
          end else begin
            state_d       = ST_DROP;
            port_vec_d    = '0;
            route_valid_d = 1'b0;
            if (drop_cnt_q != CNT_MAX) begin
              drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      ST_LOCK: begin
        in_ready_c = out_ready;
        if (cfg_we) begin
          err_proto_d = 1'b1;
        end
        if (fire_c) begin
          first_d = 1'b0;
          if (is_hdr && !first_q) begin
            err_proto_d = 1'b1;
          end
          if (is_tail) begin
            state_d       = ST_IDLE;
            port_vec_d    = '0;
            route_valid_d = 1'b0;
          end
        end
      end

      ST_DROP: begin
        in_ready_c = 1'b1;
        if (cfg_we) begin
          err_proto_d = 1'b1;
        end
        if (fire_c && is_tail) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d       = ST_IDLE;
        port_vec_d    = '0;
        route_valid_d = 1'b0;
      end
    endcase
  end

  // State, output and configuration registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      port_vec_q    <= '0;
      route_valid_q <= 1'b0;
      drop_cnt_q    <= '0;
      err_proto_q   <= 1'b0;
      first_q       <= 1'b0;
      rxy_q         <= RXY_RST;
      cx_q          <= CX_RST;
      cur_q         <= A_W'(CUR_RST);
    end else begin
      state_q       <= state_d;
      port_vec_q    <= port_vec_d;
      route_valid_q <= route_valid_d;
      drop_cnt_q    <= drop_cnt_d;
      err_proto_q   <= err_proto_d;
      first_q       <= first_d;
      rxy_q         <= rxy_d;
      cx_q          <= cx_d;
      cur_q         <= cur_d;
    end
  end

  // Nothing is consumed while reset is asserted
  assign in_ready    = in_ready_c & ~rst;
  assign route_valid = route_valid_q;
  assign port_vec    = port_vec_q;
  assign drop_cnt    = drop_cnt_q;
  assign err_proto   = err_proto_q;

endmodule

// File: doc/lbdr_route_unit.md
LBDR_ROUTE_UNIT -- requirements
Module: lbdr_route_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- X_W, 2, x-coordinate width
- Y_W, 2, y-coordinate width; address width A_W = Y_W+X_W, with y in the upper bits
- CNT_W, 8, drop-counter width
- RXY_RST, 8'd60, reset routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, LSB = Rne
- CX_RST, 4'hF, reset connectivity bits {Cs,Cw,Ce,Cn}, LSB = Cn
- CUR_RST, 5, reset own router address
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk in 1: clock
- rst in 1: reset, synchronous, active-high
- cfg_we in 1: configuration write strobe
- cfg_rxy in 8: new Rxy
- cfg_cx in 4: new Cx
- cfg_cur in A_W: new own address
- in_valid in 1: flit present at input buffer head
- in_ready out 1: flit consumed this cycle
- flit_id in 3: bit0 HEADER, bit1 PAYLOAD, bit2 TAIL; 3'b101 = single-flit packet
- dst_addr in A_W: destination, valid with header
- out_ready in 1: downstream/crossbar grant
- route_valid out 1: port_vec holds a locked route
- port_vec out 5: {L,S,W,E,N}, registered
- drop_cnt out CNT_W: dropped-packet count, saturating
- err_proto out 1: sticky protocol error

Function
REQ-003 Comparators SHALL use the configured address: N1 = y_dst<y_cur; S1 = y_dst>y_cur; E1 = x_dst>x_cur; W1 = x_dst<x_cur.
REQ-004 Candidate ports SHALL be:
- N = ((N1&~E1&~W1)|(N1&E1&Rne)|(N1&W1&Rnw))&Cn
- E = ((E1&~N1&~S1)|(E1&N1&Ren)|(E1&S1&Res))&Ce
- W = ((W1&~N1&~S1)|(W1&N1&Rwn)|(W1&S1&Rws))&Cw
- S = ((S1&~E1&~W1)|(S1&E1&Rse)|(S1&W1&Rsw))&Cs
- L = ~N1&~S1&~E1&~W1
REQ-005 FSM states SHALL be IDLE, LOCK, DROP; reset state is IDLE.
REQ-006 IDLE behaviour:
- in_valid with flit_id[0]=1 and cfg_we=0 -> header NOT consumed (in_ready=0).
- Candidate vector non-zero -> next cycle port_vec = candidate, route_valid=1, state LOCK (latency 1 cycle).
- Candidate vector all-zero -> state DROP, port_vec=0.
REQ-007 IDLE with in_valid and flit_id[0]=0 -> in_ready=1, flit discarded, err_proto set.
REQ-008 LOCK behaviour:
- in_ready = out_ready.
- A fire (in_valid&in_ready) with flit_id[2]=1 -> next cycle IDLE, port_vec=0, route_valid=0.
- Otherwise port_vec is held unchanged, including while out_ready=0.
REQ-009 LOCK: a fire with flit_id[0]=1 that is not the first flit of the packet SHALL set err_proto; port_vec is held.
REQ-010 DROP behaviour:
- in_ready=1; flits discarded until a TAIL-bit fire, then IDLE.
- drop_cnt increments once per dropped packet, on entry to DROP, saturating at 2^CNT_W-1.
REQ-011 Single-flit packet (3'b101): route locked as a normal header; the flit fire returns the FSM to IDLE.
REQ-012 cfg_we SHALL be accepted only in IDLE; it updates Rxy, Cx and cur_addr the next cycle.
- cfg_we in LOCK or DROP is ignored and sets err_proto.
- cfg_we and a header in the same IDLE cycle: config wins; the header is evaluated the following cycle with the new configuration.
REQ-013 in_ready SHALL be combinational from state, out_ready, in_valid, flit_id and cfg_we. All other outputs SHALL be registered.

Reset
REQ-014 rst SHALL set state IDLE, port_vec=0, route_valid=0, drop_cnt=0, err_proto=0, Rxy=RXY_RST, Cx=CX_RST, cur_addr=CUR_RST.
REQ-015 rst mid-packet SHALL abandon the route; the next flit is treated as arriving in IDLE.
REQ-016 in_ready SHALL be 0 during any cycle in which rst is high.

Verification (defaults; cur=5, i.e. x=1, y=1; Rxy=60; Cx=F)
REQ-017 Header dst=5 -> one cycle later port_vec=5'b10000, route_valid=1.
REQ-018 Header dst=0 -> port_vec=5'b00100 (W via Rwn). Header dst=15 -> port_vec=5'b00010 (E via Res). Header dst=1 -> port_vec=5'b00001.
REQ-019 cfg_we with cfg_cx=4'b1101, then header dst=7 -> DROP; 3-flit packet consumed with out_ready=0; drop_cnt=1; port_vec=0.
REQ-020 Locked route to E, out_ready toggled, 4-flit packet -> in_ready tracks out_ready, port_vec stable, IDLE after tail fire.
REQ-021 PAYLOAD flit in IDLE -> consumed, err_proto=1. cfg_we in LOCK -> ignored, err_proto=1. rst in LOCK -> all outputs zero next cycle.
REQ-022 With CNT_W=2, five unroutable packets -> drop_cnt saturates at 3.
